// File: rtl/bcd_serial_adder_ctrl.sv
//==============================================================================
// Module   : bcd_serial_adder_ctrl
// Purpose  : Digit-serial packed-BCD adder/accumulator. One single-digit BCD
//            add stage is reused for all DIGITS digits, LSD first, under a
//            start/done handshake FSM (IDLE -> ADD x DIGITS -> DONE).
// Ports    : clk, rst_n (async, active low)
//            start, acc        - request; acc=1 uses current sum as operand B
//            a, b [4*DIGITS]   - packed BCD operands, digit 0 in [3:0]
//            cin               - carry into digit 0
//            busy, done        - in-progress flag, one-cycle completion pulse
//            sum, cout, err    - registered result, carry out, invalid flag
// Config   : `BCD_DIGIT_CHECK_EN enables the invalid-digit (>9) check;
//            when undefined, err is tied to 0.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  acc,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS);
    localparam logic [CW-1:0] C_LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_res;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;

    logic [4:0]      w_s;
    logic [3:0]      w_dig;
    logic            w_c;
    logic [W-1:0]    w_res_next;

    // Work operands are shifted right each digit, so the current digit
    // always sits in bits [3:0].
    always_comb begin
        w_s = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0000, r_carry};
        if (w_s > 5'd9) begin
            w_dig = w_s[3:0] + 4'd6;
            w_c   = 1'b1;
        end else begin
            w_dig = w_s[3:0];
            w_c   = 1'b0;
        end
        // New digits enter at the top; after DIGITS shifts digit 0 is at LSB.
        w_res_next = {w_dig, r_res[W-1:4]};
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic r_flag;
    logic w_bad;
    assign w_bad = (r_a[3:0] > 4'd9) || (r_b[3:0] > 4'd9);
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            r_flag  <= 1'b0;
            err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        // Accumulate mode takes sum as it stands this cycle.
                        r_b     <= acc ? sum : b;
                        r_carry <= cin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                        r_flag  <= 1'b0;
`endif
                        r_state <= S_ADD;
                    end
                end

                S_ADD: begin
                    r_a     <= {4'b0000, r_a[W-1:4]};
                    r_b     <= {4'b0000, r_b[W-1:4]};
                    r_res   <= w_res_next;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                    r_flag  <= r_flag | w_bad;
`endif
                    // Last digit: publish results directly so they are valid
                    // throughout the DONE cycle together with the done pulse.
                    if (r_cnt == C_LAST) begin
                        sum     <= w_res_next;
                        cout    <= w_c;
`ifdef BCD_DIGIT_CHECK_EN
                        err     <= r_flag | w_bad;
`endif
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_adder_ctrl.sv
//==============================================================================
// Module   : tb_bcd_serial_adder_ctrl
// Purpose  : Directed self-checking bench for bcd_serial_adder_ctrl
//            (DIGITS = 4) with hand-computed expected values.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bcd_serial_adder_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          acc;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BCD_DIGIT_CHECK_EN
    localparam logic C_ERR_EXP = 1'b1;
`else
    localparam logic C_ERR_EXP = 1'b0;
`endif

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .acc   (acc),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and check latency, results and the
    // return to IDLE. Returns in the first IDLE cycle after DONE.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tcin, input logic tacc,
                          input logic [W-1:0] esum, input logic ecout, input logic eerr);
        int lat;
        a = ta; b = tb_; cin = tcin; acc = tacc; start = 1'b1;
        step();
        start = 1'b0; a = '1; b = '1; cin = 1'b0; acc = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_lat"},  lat,  DIGITS + 1);
        chk({tag, "_sum"},  sum,  esum);
        chk({tag, "_cout"}, cout, ecout);
        chk({tag, "_err"},  err,  eerr);
        chk({tag, "_busy"}, busy, 1'b1);
        step();
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_idle_done"}, done, 1'b0);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; acc = 1'b0; a = '0; b = '0; cin = 1'b0;
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum",  sum,  16'h0000);
        chk("rst_cout", cout, 1'b0);
        chk("rst_err",  err,  1'b0);
        rst_n = 1'b1;
        step();

        // Basic adds and carry boundaries
        run_op("add72_45",  16'h0072, 16'h0045, 1'b0, 1'b0, 16'h0117, 1'b0, 1'b0);
        run_op("wrap9999",  16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin99_99",  16'h0099, 16'h0099, 1'b1, 1'b0, 16'h0199, 1'b0, 1'b0);

        // Accumulate chain: b ignored when acc=1
        run_op("pre_acc",   16'h0072, 16'h0045, 1'b0, 1'b0, 16'h0117, 1'b0, 1'b0);
        run_op("acc1",      16'h0883, 16'h5555, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
        run_op("acc2",      16'h9000, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Start pulses during ADD (cycle 2) and DONE (cycle 5) are ignored
        a = 16'h0072; b = 16'h0045; cin = 1'b0; acc = 1'b0; start = 1'b1;
        step();
        ndone = 0;
        for (int c = 1; c <= 5; c++) begin
            start = (c == 2 || c == 5);
            if (c == 2) begin a = 16'h1111; b = 16'h2222; end
            if (done) ndone++;
            if (c == 5) chk("ign_sum", sum, 16'h0117);
            step();
        end
        start = 1'b0;
        if (done) ndone++;
        chk("ign_ndone", ndone, 1);
        chk("ign_busy6", busy, 1'b0);
        run_op("restart6",  16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

        // Reset in the middle of an operation over a prior sum of 0x0117
        run_op("pre_rst",   16'h0072, 16'h0045, 1'b0, 1'b0, 16'h0117, 1'b0, 1'b0);
        a = 16'h0500; b = 16'h0400; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_sum",  sum,  16'h0000);
        chk("arst_cout", cout, 1'b0);
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            step();
        end
        chk("arst_nodone", ndone, 0);
        run_op("post_rst",  16'h0072, 16'h0045, 1'b0, 1'b0, 16'h0117, 1'b0, 1'b0);

        // Invalid digit: err only with the check enabled; sum follows the rule
        run_op("bad_digit", 16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, C_ERR_EXP);
        run_op("after_bad", 16'h0012, 16'h0034, 1'b0, 1'b0, 16'h0046, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Digit-serial BCD add/accumulate controller. One single-digit BCD add stage is reused across all DIGITS digits of a packed-BCD operand pair, LSD first, under an FSM with a start/done handshake. It wraps the team's BCD adder datapath so that wide BCD operands, such as counter/display accumulators, can be summed with one digit adder instead of a ripple chain. A running-total mode lets the block act as a BCD accumulator.

## Interface
- DIGITS, default 4: number of BCD digits per operand; legal range 2..8.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- acc  input  1  sampled with start: 1 = use current `sum` register as operand B instead of `b`.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  input  4*DIGITS  operand B, packed BCD.
- cin  input  1  carry into digit 0.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when `sum`/`cout`/`err` update.
- sum  output  4*DIGITS  registered result; holds until the next completion.
- cout  output  1  carry out of the most significant digit.
- err  output  1  invalid-digit flag for the last operation (see Configuration).

## Operation
- FSM states and transitions:
  - IDLE: on start=1, latch a, B (b or sum, per acc) and cin into work registers; digit counter = 0; go to ADD.
  - ADD: each cycle processes digit k = counter.
  - DONE: one cycle, then IDLE.
- Digit arithmetic: s = a_k + b_k + c (5-bit). If s > 9: digit = (s + 6)[3:0], c' = 1. Otherwise digit = s[3:0], c' = 0.
- Each processed digit is shifted into a result shift register. The carry is registered between digits.
- ADD → DONE after the digit with counter = DIGITS-1 is processed.
- DONE cycle:
  - copy result to `sum`, final carry to `cout`, invalid-flag to `err`;
  - done = 1.
- `start` in ADD or DONE is ignored; it is not queued.
- acc=1 reads `sum` as it stood at the start cycle.
- All arithmetic is modulo 10^DIGITS; overflow is reported only via `cout`.
- Inputs a/b/cin/acc are don't-care except in the start cycle.

## Timing
- Reset (async, any state) forces:
  - state = IDLE;
  - busy = 0, done = 0, sum = 0, cout = 0, err = 0;
  - work registers and counter = 0.
- An operation aborted by reset never produces `done`.
- Cycle 0: start=1 sampled in IDLE.
- Cycles 1..DIGITS: busy = 1, one digit per cycle.
- Cycle DIGITS+1: DONE state; done = 1, busy = 1; `sum`/`cout`/`err` are valid from this cycle onward.
- Cycle DIGITS+2: IDLE, busy = 0; start is accepted here at the earliest.
- Latency: start to done = DIGITS+1 cycles.
- Throughput: one operation per DIGITS+2 cycles.
- `busy` is asserted from the cycle after start until the end of the DONE cycle.
- No combinational path from inputs to outputs.

## Configuration
- Macro `BCD_DIGIT_CHECK_EN`.
- Defined:
  - each cycle in ADD, a_k > 9 or b_k > 9 sets a sticky internal flag, cleared at start;
  - `err` takes the flag in the DONE cycle;
  - the sum is still computed by the arithmetic rule above.
- Undefined: no check logic; `err` is tied to 0.

## Test plan (DIGITS = 4)
- a=0x0072, b=0x0045, cin=0 → done at cycle 5; sum=0x0117, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1. Separately, a=0x0099, b=0x0099, cin=1 → sum=0x0199, cout=0.
- Accumulate:
  - after the 0x0117 result, start with acc=1, a=0x0883, b=0x5555 → sum=0x1000; b is ignored;
  - a second acc=1 with a=0x9000 → sum=0x0000, cout=1.
- Start pulsed at cycles 2 and 5 during an operation → ignored; exactly one done pulse; a restart is accepted at cycle 6.
- rst_n low at cycle 2 of an operation over a prior sum=0x0117 → all outputs 0 immediately; no done; the next operation behaves normally.
- With BCD_DIGIT_CHECK_EN: a=0x00A0, b=0x0000 → err=1, sum=0x0100. The next valid operation returns err=0. Without the macro, the same stimulus gives err=0.
